// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, FSM states and BCD helpers for the RTC counter
package rtc_pkg;

    localparam int TIME_W      = 24;

    localparam int S_U         = 0;
    localparam int S_T         = 4;
    localparam int M_U         = 8;
    localparam int M_T         = 12;
    localparam int H_U         = 16;
    localparam int H_T         = 20;

    localparam logic [3:0] MAX_UNIT    = 4'd9;
    localparam logic [3:0] MAX_TENS_MS = 4'd5;
    localparam logic [7:0] MAX_HOUR    = 8'h23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } rtc_state_t;

    // True when every digit is decimal and the fields are within clock range.
    // Hours are compared as packed BCD, which orders correctly once both digits are decimal.
    function automatic logic bcd_time_valid(input logic [TIME_W-1:0] t);
        logic ok;
        ok = 1'b1;
        if (t[S_U+:4] > MAX_UNIT)    ok = 1'b0;
        if (t[S_T+:4] > MAX_TENS_MS) ok = 1'b0;
        if (t[M_U+:4] > MAX_UNIT)    ok = 1'b0;
        if (t[M_T+:4] > MAX_TENS_MS) ok = 1'b0;
        if (t[H_U+:4] > MAX_UNIT)    ok = 1'b0;
        if (t[H_T+:4] > MAX_UNIT)    ok = 1'b0;
        if (t[H_U+:8] > MAX_HOUR)    ok = 1'b0;
        return ok;
    endfunction

    // One-second increment with the full carry chain resolved combinationally.
    function automatic logic [TIME_W-1:0] bcd_time_next(input logic [TIME_W-1:0] t);
        logic [TIME_W-1:0] n;
        n = t;
        if (t[S_U+:4] != MAX_UNIT) begin
            n[S_U+:4] = t[S_U+:4] + 4'd1;
        end else begin
            n[S_U+:4] = 4'd0;
            if (t[S_T+:4] != MAX_TENS_MS) begin
                n[S_T+:4] = t[S_T+:4] + 4'd1;
            end else begin
                n[S_T+:4] = 4'd0;
                if (t[M_U+:4] != MAX_UNIT) begin
                    n[M_U+:4] = t[M_U+:4] + 4'd1;
                end else begin
                    n[M_U+:4] = 4'd0;
                    if (t[M_T+:4] != MAX_TENS_MS) begin
                        n[M_T+:4] = t[M_T+:4] + 4'd1;
                    end else begin
                        n[M_T+:4] = 4'd0;
                        if (t[H_U+:8] == MAX_HOUR) begin
                            n[H_U+:8] = 8'h00;
                        end else if (t[H_U+:4] == MAX_UNIT) begin
                            n[H_U+:4] = 4'd0;
                            n[H_T+:4] = t[H_T+:4] + 4'd1;
                        end else begin
                            n[H_U+:4] = t[H_U+:4] + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// rtl/tick_edge_sync.sv - synchroniser and registered rising-edge detector for the divider tick
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    // Shift the asynchronous tick through the synchroniser chain, then register the edge
    // so the pulse appears SYNC_STAGES+1 clocks after the input rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_tick};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/rtc_bcd_counter.sv
// rtl/rtc_bcd_counter.sv - BCD HH:MM:SS time-of-day counter; optional alarm via RTC_ALARM_EN
module rtc_bcd_counter
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 30,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_in,
    input  logic              run_en,
    input  logic              set_valid,
    input  logic [TIME_W-1:0] set_time,
    output logic              set_ready,
    output logic              set_err,
    output logic [TIME_W-1:0] time_bcd,
`ifdef RTC_ALARM_EN
    input  logic [TIME_W-1:0] alarm_bcd,
    output logic              alarm_hit,
`endif
    output logic              upd
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    rtc_state_t        r_state;
    rtc_state_t        w_state_nxt;
    logic [PW-1:0]     r_presc;
    logic [TIME_W-1:0] r_time;
    logic              r_upd;
    logic              r_set_ready;
    logic              r_set_err;
    logic              w_tick_rise;
    logic              w_accept;
    logic              w_load_go;
    logic              w_load_bad;
    logic              w_count;
    logic              w_set_ready_nxt;
`ifdef RTC_ALARM_EN
    logic              r_alarm_hit;
`endif

    tick_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_tick (tick_in),
        .o_rise (w_tick_rise)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus load/count decisions; an accepted valid load always beats a tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = set_valid & r_set_ready;
        w_load_go       = 1'b0;
        w_load_bad      = 1'b0;
        w_count         = 1'b0;
        w_set_ready_nxt = 1'b1;
        if (w_accept) begin
            w_load_go  = bcd_time_valid(set_time);
            w_load_bad = ~w_load_go;
        end
        case (r_state)
            IDLE: begin
                if (w_load_go) begin
                    w_state_nxt = LOAD;
                end else if (run_en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_count = w_tick_rise & ~w_load_go;
                if (w_load_go) begin
                    w_state_nxt = LOAD;
                end else if (!run_en) begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_state_nxt = run_en ? RUN : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_state_nxt == LOAD) begin
            w_set_ready_nxt = 1'b0;
        end
    end

    // Prescaler, time register and the one-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_time      <= '0;
            r_upd       <= 1'b0;
            r_set_ready <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            r_upd       <= 1'b0;
            r_set_err   <= w_load_bad;
            r_set_ready <= w_set_ready_nxt;
            if (w_load_go) begin
                r_time  <= set_time;
                r_presc <= '0;
                r_upd   <= 1'b1;
            end else if (w_count) begin
                if (r_presc == PRESC_LAST) begin
                    r_presc <= '0;
                    r_time  <= bcd_time_next(r_time);
                    r_upd   <= 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

`ifdef RTC_ALARM_EN
    // Alarm fires only on a counted advance, never on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm_hit <= 1'b0;
        end else begin
            r_alarm_hit <= w_count && (r_presc == PRESC_LAST) &&
                           (bcd_time_next(r_time) == alarm_bcd);
        end
    end

    assign alarm_hit = r_alarm_hit;
`endif

    assign time_bcd  = r_time;
    assign upd       = r_upd;
    assign set_ready = r_set_ready;
    assign set_err   = r_set_err;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// tb/tb_rtc_bcd_counter.sv - directed self-checking bench for rtc_bcd_counter
module tb_rtc_bcd_counter;

    logic        clk;
    logic        rst_n;
    logic        tick_in;
    logic        run_en;
    logic        set_valid;
    logic [23:0] set_time;
    logic        set_ready;
    logic        set_err;
    logic [23:0] time_bcd;
    logic        upd;
`ifdef RTC_ALARM_EN
    logic [23:0] alarm_bcd;
    logic        alarm_hit;
    int          alarm_cnt;
`endif

    int n_vec;
    int n_miss;
    int upd_cnt;
    int err_cnt;
    int upd_base;

    rtc_bcd_counter #(
        .TICKS_PER_SEC (30),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .run_en    (run_en),
        .set_valid (set_valid),
        .set_time  (set_time),
        .set_ready (set_ready),
        .set_err   (set_err),
        .time_bcd  (time_bcd),
`ifdef RTC_ALARM_EN
        .alarm_bcd (alarm_bcd),
        .alarm_hit (alarm_hit),
`endif
        .upd       (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && upd)     upd_cnt++;
        if (rst_n && set_err) err_cnt++;
`ifdef RTC_ALARM_EN
        if (rst_n && alarm_hit) alarm_cnt++;
`endif
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_in = 1'b1;
            repeat (3) @(negedge clk);
            tick_in = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_load(input logic [23:0] v);
        @(negedge clk);
        set_valid = 1'b1;
        set_time  = v;
        @(negedge clk);
        set_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_miss = 0; upd_cnt = 0; err_cnt = 0;
        rst_n = 1'b0; tick_in = 1'b0; run_en = 1'b0;
        set_valid = 1'b0; set_time = 24'h0;
`ifdef RTC_ALARM_EN
        alarm_bcd = 24'h000010; alarm_cnt = 0;
`endif
        repeat (3) @(negedge clk);
        check_vec("rst_time", time_bcd, 24'h000000);
        check_vec("rst_upd", upd, 1'b0);
        check_vec("rst_ready", set_ready, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("ready_after_rst", set_ready, 1'b1);

        // idle freezes time
        tick_edges(30);
        check_vec("idle_time", time_bcd, 24'h000000);
        check_vec("idle_upd", upd_cnt, 0);

        // one second
        run_en = 1'b1;
        repeat (2) @(negedge clk);
        tick_edges(29);
        check_vec("29_edges_upd", upd_cnt, 0);
        check_vec("29_edges_time", time_bcd, 24'h000000);
        tick_edges(1);
        check_vec("30_edges_upd", upd_cnt, 1);
        check_vec("30_edges_time", time_bcd, 24'h000001);

        // full wrap
        do_load(24'h235959);
        check_vec("load_2359_time", time_bcd, 24'h235959);
        check_vec("load_upd", upd_cnt, 2);
        tick_edges(30);
        check_vec("wrap_time", time_bcd, 24'h000000);
        check_vec("wrap_upd", upd_cnt, 3);

        // hour-tens carry
        do_load(24'h095959);
        tick_edges(30);
        check_vec("h_carry_time", time_bcd, 24'h100000);
        check_vec("h_carry_upd", upd_cnt, 5);

        // invalid loads
        do_load(24'h246000);
        check_vec("bad1_err", err_cnt, 1);
        check_vec("bad1_time", time_bcd, 24'h100000);
        check_vec("bad1_ready", set_ready, 1'b1);
        do_load(24'h125960);
        check_vec("bad2_err", err_cnt, 2);
        check_vec("bad2_time", time_bcd, 24'h100000);
        check_vec("bad_upd", upd_cnt, 5);

        // load collides with due advance
        tick_edges(29);
        @(negedge clk) tick_in = 1'b1;
        repeat (3) @(negedge clk);
        set_valid = 1'b1;
        set_time  = 24'h120000;
        @(negedge clk);
        set_valid = 1'b0;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        repeat (6) @(negedge clk);
        check_vec("collide_time", time_bcd, 24'h120000);
        check_vec("collide_upd", upd_cnt, 6);
        tick_edges(29);
        check_vec("collide_29_time", time_bcd, 24'h120000);
        tick_edges(1);
        check_vec("collide_30_time", time_bcd, 24'h120001);

        // load while frozen is accepted
        run_en = 1'b0;
        repeat (2) @(negedge clk);
        upd_base = upd_cnt;
        do_load(24'h000004);
        check_vec("idle_load_time", time_bcd, 24'h000004);
        check_vec("idle_load_upd", upd_cnt, upd_base + 1);
        run_en = 1'b1;
        repeat (2) @(negedge clk);

        // reset mid-second
        tick_edges(30);
        check_vec("pre_rst_time", time_bcd, 24'h000005);
        tick_edges(10);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_vec("async_rst_time", time_bcd, 24'h000000);
        check_vec("async_rst_ready", set_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef RTC_ALARM_EN
        do_load(24'h000010);
        check_vec("alarm_load_nofire", alarm_cnt, 0);
        do_load(24'h000009);
        tick_edges(30);
        check_vec("alarm_time", time_bcd, 24'h000010);
        check_vec("alarm_once", alarm_cnt, 1);
        tick_edges(30);
        check_vec("alarm_no_refire", alarm_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
